// File: rtl/avalon_gpio_port.sv
// -----------------------------------------------------------------------------
// avalon_gpio_port
//
// General-purpose I/O port with an Avalon-MM slave register interface.
// It has a per-bit direction register, an output data register with
// set and clear aliases, edge capture on synchronized pad inputs, and a
// maskable level interrupt.
//
// Bus handshake: the slave has no wait states. A write completes on the
// rising clk edge where chipselect=1 and write_n=0. Reads have no latency:
// readdata always reflects the register selected by address, whether or not
// chipselect is asserted.
//
// Register map (word address):
//   0 DATA    write: data_out     read: pin_sync for input bits, data_out for output bits
//   1 DIR     write/read: dir (1 = output)
//   2 IRQMASK write/read: mask
//   3 EDGECAP write: W1C clear    read: capture
//   4 OUTSET  write: data_out |= wd  read: 0
//   5 OUTCLR  write: data_out &= ~wd read: 0
//   6-7       reserved, read 0, writes ignored
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM write/address inputs
//   readdata                Avalon-MM read data, zero-extended above WIDTH-1
//   pin_in                  asynchronous pad inputs
//   out_port                output data register
//   oe                      per-bit output enable (the direction register)
//   irq                     active-high level interrupt
// -----------------------------------------------------------------------------
module avalon_gpio_port #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] OUT_RESET = 32'd0,
  parameter logic [31:0] DIR_RESET = 32'd0,
  parameter int          EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam logic [WIDTH-1:0] OUT_RST_W = OUT_RESET[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_RST_W = DIR_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_prev;
  logic [1:0]       arm_cnt;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out_next;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] edge_evt;
  logic             armed;
  logic [WIDTH-1:0] rd_w;

  // Bits of writedata above WIDTH-1 are deliberately ignored.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[WIDTH-1:0];

  // The arm counter keeps the synchronizer's first transitions out of
  // reset (e.g. pins already high) from being taken as real edges.
  assign armed = (arm_cnt == 2'd3);

  always_comb begin
    data_out_next = data_out;
    w1c           = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_out_next = wd;
        ADDR_OUTSET:  data_out_next = data_out | wd;
        ADDR_OUTCLR:  data_out_next = data_out & ~wd;
        ADDR_EDGECAP: w1c           = wd;
        default:      data_out_next = data_out;
      endcase
    end
  end

  always_comb begin
    edge_evt = pin_sync & ~pin_prev;
    case (EDGE_TYPE)
      1:       edge_evt = ~pin_sync & pin_prev;
      2:       edge_evt = pin_sync ^ pin_prev;
      default: edge_evt = pin_sync & ~pin_prev;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= OUT_RST_W;
      dir      <= DIR_RST_W;
      mask     <= '0;
      capture  <= '0;
      sync1    <= '0;
      pin_sync <= '0;
      pin_prev <= '0;
      arm_cnt  <= 2'd0;
    end else begin
      data_out <= data_out_next;
      if (wr_en && address == ADDR_DIR)     dir  <= wd;
      if (wr_en && address == ADDR_IRQMASK) mask <= wd;
      // A fresh event outranks a W1C landing on the same edge.
      capture  <= (capture & ~w1c) | (armed ? edge_evt : '0);
      sync1    <= pin_in;
      pin_sync <= sync1;
      pin_prev <= pin_sync;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA:    rd_w = (pin_sync & ~dir) | (data_out & dir);
      ADDR_DIR:     rd_w = dir;
      ADDR_IRQMASK: rd_w = mask;
      ADDR_EDGECAP: rd_w = capture;
      default:      rd_w = '0;
    endcase
  end

  assign readdata = 32'(rd_w);
  assign out_port = data_out;
  assign oe       = dir;
  assign irq      = |(capture & mask);

endmodule

// File: tb/tb_avalon_gpio_port.sv
// -----------------------------------------------------------------------------
// tb_avalon_gpio_port
//
// Three builds share one clock, reset and bus:
//   u8  : WIDTH=8,  rising capture, reset values 0
//   u1  : WIDTH=1,  falling capture, OUT_RESET=1
//   u32 : WIDTH=32, any-edge capture, non-zero reset values
// The reference model keeps the full history of pin values applied before
// each edge since reset release and derives synchronized values and edge
// events from that history by edge index.
// -----------------------------------------------------------------------------
module tb_avalon_gpio_port;

  localparam int HMAX = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [7:0]  pin8 = '0;
  logic [0:0]  pin1 = '0;
  logic [31:0] pin32 = '0;

  logic [31:0] rd8, rd1, rd32;
  logic [7:0]  out8, oe8;
  logic [0:0]  out1, oe1;
  logic [31:0] out32, oe32;
  logic        irq8, irq1, irq32;

  avalon_gpio_port #(.WIDTH(8), .OUT_RESET(32'h0), .DIR_RESET(32'h0), .EDGE_TYPE(0)) u8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd8), .pin_in(pin8),
    .out_port(out8), .oe(oe8), .irq(irq8));

  avalon_gpio_port #(.WIDTH(1), .OUT_RESET(32'h1), .DIR_RESET(32'h0), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .pin_in(pin1),
    .out_port(out1), .oe(oe1), .irq(irq1));

  avalon_gpio_port #(.WIDTH(32), .OUT_RESET(32'h1234_5678), .DIR_RESET(32'hFFFF_0000),
                     .EDGE_TYPE(2)) u32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd32), .pin_in(pin32),
    .out_port(out32), .oe(oe32), .irq(irq32));

  // ---------------- reference model ----------------
  logic [31:0] m_data [3];
  logic [31:0] m_dir  [3];
  logic [31:0] m_mask [3];
  logic [31:0] m_cap  [3];
  int          m_cnt  [3];            // edges since reset release
  logic [31:0] hist   [3][0:HMAX-1];  // hist[i][k] = pin value before edge k

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] wmask(int i);
    case (i)
      0:       return 32'h0000_00FF;
      1:       return 32'h0000_0001;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] out_reset(int i);
    case (i)
      0:       return 32'h0;
      1:       return 32'h1;
      default: return 32'h1234_5678;
    endcase
  endfunction

  function automatic logic [31:0] dir_reset(int i);
    return (i == 2) ? 32'hFFFF_0000 : 32'h0;
  endfunction

  function automatic logic [31:0] pin_of(int i);
    case (i)
      0:       return 32'(pin8);
      1:       return 32'(pin1);
      default: return pin32;
    endcase
  endfunction

  function automatic logic [31:0] h_at(int i, int k);
    return (k >= 1) ? hist[i][k] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_read(int i, logic [2:0] a);
    logic [31:0] ps;
    ps = h_at(i, m_cnt[i] - 1);  // value now held in the second sync stage
    case (a)
      3'd0:    return (ps & ~m_dir[i]) | (m_data[i] & m_dir[i]);
      3'd1:    return m_dir[i];
      3'd2:    return m_mask[i];
      3'd3:    return m_cap[i];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] obs_read(int i);
    case (i)
      0:       return rd8;
      1:       return rd1;
      default: return rd32;
    endcase
  endfunction

  function automatic logic [31:0] obs_out(int i);
    case (i)
      0:       return 32'(out8);
      1:       return 32'(out1);
      default: return out32;
    endcase
  endfunction

  function automatic logic [31:0] obs_oe(int i);
    case (i)
      0:       return 32'(oe8);
      1:       return 32'(oe1);
      default: return oe32;
    endcase
  endfunction

  function automatic logic obs_irq(int i);
    case (i)
      0:       return irq8;
      1:       return irq1;
      default: return irq32;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = out_reset(i);
      m_dir[i]  = dir_reset(i);
      m_mask[i] = '0;
      m_cap[i]  = '0;
      m_cnt[i]  = 0;
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/u%0d/out", tag, i), obs_out(i), m_data[i]);
      check($sformatf("%s/u%0d/oe", tag, i), obs_oe(i), m_dir[i]);
      check($sformatf("%s/u%0d/irq", tag, i), 32'(obs_irq(i)), 32'(|(m_cap[i] & m_mask[i])));
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      for (int i = 0; i < 3; i++)
        check($sformatf("%s/u%0d/rd%0d", tag, i, a), obs_read(i), exp_read(i, 3'(a)));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model state is computed from the inputs in place now,
  // then committed at the edge. Returns at the following falling edge.
  task automatic tick();
    logic [31:0] nd [3], ndir [3], nmask [3], ncap [3];
    for (int i = 0; i < 3; i++) begin
      logic [31:0] wm, w, w1c, h2, h3, ev;
      int k;
      wm = wmask(i);
      w  = writedata & wm;
      k  = m_cnt[i] + 1;
      if (k >= HMAX) k = HMAX - 1;
      hist[i][k] = pin_of(i) & wm;
      h2 = h_at(i, k - 2);
      h3 = h_at(i, k - 3);
      case (i)
        0:       ev = h2 & ~h3;
        1:       ev = ~h2 & h3;
        default: ev = h2 ^ h3;
      endcase
      ev = ev & wm;
      nd[i] = m_data[i]; ndir[i] = m_dir[i]; nmask[i] = m_mask[i]; w1c = '0;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: nd[i] = w;
          3'd1: ndir[i] = w;
          3'd2: nmask[i] = w;
          3'd3: w1c = w;
          3'd4: nd[i] = m_data[i] | w;
          3'd5: nd[i] = m_data[i] & ~w;
          default: ;
        endcase
      end
      // Edges only count from the fourth edge after release onward.
      ncap[i] = (m_cap[i] & ~w1c) | ((k >= 4) ? ev : 32'h0);
      m_cnt[i] = k;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_data[i] = nd[i]; m_dir[i] = ndir[i]; m_mask[i] = nmask[i]; m_cap[i] = ncap[i];
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  // Reset is asserted between edges so its effect is seen asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_irq8", 32'(irq8), 32'h0);
    check_all("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // Reset values
    do_reset();
    check("rst_out32", out32, 32'h1234_5678);
    check("rst_oe32", oe32, 32'hFFFF_0000);
    ticks(5);
    check_all("post_reset");

    // Output data register and its set/clear aliases
    do_write(3'd0, 32'hFFFF_FFA5);
    check("data_a5", 32'(out8), 32'hA5);
    do_write(3'd4, 32'h0000_000F);
    check("outset_af", 32'(out8), 32'hAF);
    do_write(3'd5, 32'h0000_0081);
    check("outclr_2e", 32'(out8), 32'h2E);
    do_write(3'd1, 32'h0000_00F0);
    address = 3'd1; #1;
    check("dir_rb", rd8, 32'hF0);
    check_all("regs");

    // Mixed-direction DATA read
    pin8 = 8'h3C;
    ticks(3);
    address = 3'd0; #1;
    check("data_mixed", rd8, 32'h2C);
    check_all("mixed");

    // Capture latency, interrupt and W1C
    do_write(3'd3, 32'hFF);
    do_write(3'd2, 32'h01);
    pin8 = 8'h3D;
    tick();
    tick();
    check("irq_n1", 32'(irq8), 32'h0);
    tick();
    check("irq_n2", 32'(irq8), 32'h1);
    address = 3'd3; #1;
    check("cap_n2", rd8, 32'h01);
    do_write(3'd3, 32'h01);
    check("irq_w1c", 32'(irq8), 32'h0);
    check_all("w1c");

    // W1C colliding with a new event on the same edge
    pin8 = 8'h3C;
    ticks(3);
    pin8 = 8'h3D;
    tick();
    tick();
    do_write(3'd3, 32'h01);
    check("set_wins_irq", 32'(irq8), 32'h1);
    address = 3'd3; #1;
    check("set_wins_cap", rd8, 32'h01);
    check_all("collide");

    // Mid-operation reset with pins held high, then a pulse on bit 2
    pin8 = 8'hFF; pin1 = 1'b1; pin32 = 32'hFFFF_FFFF;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      tick();
      address = 3'd3; #1;
      check($sformatf("no_false_cap%0d", j), rd8, 32'h0);
    end
    check_all("armed");
    pin8 = 8'hFB;
    ticks(3);
    pin8 = 8'hFF;
    ticks(4);
    address = 3'd3; #1;
    check("pulse_bit2", rd8, 32'h04);
    check_all("pulse");

    // Reserved addresses and width truncation
    do_write(3'd6, 32'hDEAD_BEEF);
    do_write(3'd7, 32'hFFFF_FFFF);
    check_all("reserved");
    do_write(3'd0, 32'hFFFF_FFFE);
    check("w1_trunc", 32'(out1), 32'h0);
    do_write(3'd1, 32'hFFFF_FFFF);
    address = 3'd1; #1;
    check("w8_dir_hi0", rd8, 32'hFF);
    check("w1_dir_hi0", rd1, 32'h1);
    check_all("trunc");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) pin8 = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pin1 = 1'($urandom);
      if ($urandom_range(0, 2) == 0) pin32 = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: tick();
        3:       do_write(3'd3, $urandom);
        9:       if ($urandom_range(0, 9) == 0) do_reset(); else tick();
        default: do_write(3'($urandom_range(0, 7)), $urandom);
      endcase
      check_all($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout tests=%0d", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
